// File: rtl/hms_countdown.sv
// 12-hour h:m:s countdown timer: loads a duration, decrements once per tick,
// pulses done on reaching 00:00:00 and holds in EXPIRED until reloaded or cleared.
module hms_countdown (
  input  logic       clk,
  input  logic       async_rst,
  input  logic       tick,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_h,
  input  logic [5:0] load_m,
  input  logic [5:0] load_s,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       done,
  output logic       expired,
  output logic       load_err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_h;
  logic [5:0] r_m;
  logic [5:0] r_s;
  logic [3:0] w_h_nxt;
  logic [5:0] w_m_nxt;
  logic [5:0] w_s_nxt;
  logic       r_done;
  logic       r_load_err;
  logic       w_done_nxt;
  logic       w_load_err_nxt;
  logic       w_load_ok;
  logic       w_zero;
  logic       w_last;

  assign w_load_ok = (load_h <= 4'd11) && (load_m <= 6'd59) && (load_s <= 6'd59);
  assign w_zero    = (r_h == 4'd0) && (r_m == 6'd0) && (r_s == 6'd0);
  assign w_last    = (r_h == 4'd0) && (r_m == 6'd0) && (r_s == 6'd1);

  // Priority chain: clear > load > pause > start > tick; only the top active request acts.
  always_comb begin
    w_state_nxt    = r_state;
    w_h_nxt        = r_h;
    w_m_nxt        = r_m;
    w_s_nxt        = r_s;
    w_done_nxt     = 1'b0;
    w_load_err_nxt = 1'b0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_h_nxt     = 4'd0;
      w_m_nxt     = 6'd0;
      w_s_nxt     = 6'd0;
    end else if (load) begin
      if (r_state != ST_RUN) begin
        if (w_load_ok) begin
          w_state_nxt = ST_IDLE;
          w_h_nxt     = load_h;
          w_m_nxt     = load_m;
          w_s_nxt     = load_s;
        end else begin
          w_load_err_nxt = 1'b1;
        end
      end
    end else if (pause) begin
      if (r_state == ST_RUN) w_state_nxt = ST_PAUSED;
    end else if (start) begin
      if ((r_state == ST_IDLE || r_state == ST_PAUSED) && !w_zero) w_state_nxt = ST_RUN;
    end else if (tick && r_state == ST_RUN) begin
      // Count is never zero in RUN, so the hours borrow cannot underflow.
      if (r_s != 6'd0) begin
        w_s_nxt = r_s - 6'd1;
      end else begin
        w_s_nxt = 6'd59;
        if (r_m != 6'd0) begin
          w_m_nxt = r_m - 6'd1;
        end else begin
          w_m_nxt = 6'd59;
          w_h_nxt = r_h - 4'd1;
        end
      end
      if (w_last) begin
        w_state_nxt = ST_EXPIRED;
        w_done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_state    <= ST_IDLE;
      r_h        <= 4'd0;
      r_m        <= 6'd0;
      r_s        <= 6'd0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_h        <= w_h_nxt;
      r_m        <= w_m_nxt;
      r_s        <= w_s_nxt;
      r_done     <= w_done_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  assign hours     = r_h;
  assign minutes   = r_m;
  assign seconds   = r_s;
  assign done      = r_done;
  assign load_err  = r_load_err;
  assign running   = (r_state == ST_RUN);
  assign expired   = (r_state == ST_EXPIRED);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hms_countdown.sv
// Directed bench for hms_countdown: each task drives one scenario and checks
// hand-computed count, state and pulse values inline.
module tb_hms_countdown;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSED  = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  logic       clk;
  logic       async_rst;
  logic       tick;
  logic       clear;
  logic       load;
  logic [3:0] load_h;
  logic [5:0] load_m;
  logic [5:0] load_s;
  logic       start;
  logic       pause;
  logic [3:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       done;
  logic       expired;
  logic       load_err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] e;

  hms_countdown dut (
    .clk(clk), .async_rst(async_rst), .tick(tick), .clear(clear), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s), .start(start), .pause(pause),
    .hours(hours), .minutes(minutes), .seconds(seconds), .running(running),
    .done(done), .expired(expired), .load_err(load_err), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // Driver tasks: inputs change 1ns after the rising edge, outputs sampled there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [3:0] h, input logic [5:0] m, input logic [5:0] s);
    load = 1'b1; load_h = h; load_m = m; load_s = s;
    cyc();
    load = 1'b0;
  endtask

  task automatic drive_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic drive_pause();
    pause = 1'b1; cyc(); pause = 1'b0;
  endtask

  task automatic drive_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic drive_tick();
    tick = 1'b1; cyc(); tick = 1'b0;
  endtask

  task automatic test_reset();
    async_rst = 1'b1;
    cyc();
    n_checks++; if ({hours, minutes, seconds} !== 16'd0) $display("FAIL rst_count got %0d:%0d:%0d exp 0:0:0", hours, minutes, seconds); else n_pass++;
    n_checks++; if ({running, done, expired, load_err} !== 4'b0000) $display("FAIL rst_flags got %b exp 0000", {running, done, expired, load_err}); else n_pass++;
    n_checks++; if (dbg_state !== S_IDLE) $display("FAIL rst_state got %0d exp %0d", dbg_state, S_IDLE); else n_pass++;
    async_rst = 1'b0;
    cyc();
    n_checks++; if (dbg_state !== S_IDLE) $display("FAIL rst_release_state got %0d exp %0d", dbg_state, S_IDLE); else n_pass++;
  endtask

  task automatic test_countdown();
    drive_load(4'd0, 6'd0, 6'd3);
    n_checks++; if ({hours, minutes, seconds} !== {4'd0, 6'd0, 6'd3}) $display("FAIL cd_load got %0d:%0d:%0d exp 0:0:3", hours, minutes, seconds); else n_pass++;
    n_checks++; if (dbg_state !== S_IDLE) $display("FAIL cd_load_state got %0d exp %0d", dbg_state, S_IDLE); else n_pass++;
    drive_start();
    n_checks++; if (running !== 1'b1) $display("FAIL cd_running got %b exp 1", running); else n_pass++;
    exp_q.push_back({4'd0, 6'd0, 6'd2});
    exp_q.push_back({4'd0, 6'd0, 6'd1});
    exp_q.push_back({4'd0, 6'd0, 6'd0});
    tick = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      e = exp_q.pop_front();
      n_checks++; if ({hours, minutes, seconds} !== e) $display("FAIL cd_tick%0d got %0d:%0d:%0d exp %0d:%0d:%0d", k, hours, minutes, seconds, e[15:12], e[11:6], e[5:0]); else n_pass++;
      n_checks++; if (done !== (k == 2)) $display("FAIL cd_done%0d got %b exp %b", k, done, (k == 2)); else n_pass++;
    end
    n_checks++; if (expired !== 1'b1 || dbg_state !== S_EXPIRED) $display("FAIL cd_expired got %b/%0d exp 1/%0d", expired, dbg_state, S_EXPIRED); else n_pass++;
    cyc();
    tick = 1'b0;
    n_checks++; if ({hours, minutes, seconds} !== 16'd0) $display("FAIL cd_hold got %0d:%0d:%0d exp 0:0:0", hours, minutes, seconds); else n_pass++;
    n_checks++; if (done !== 1'b0 || expired !== 1'b1) $display("FAIL cd_hold_flags got done=%b exp=%b want 0/1", done, expired); else n_pass++;
  endtask

  task automatic test_borrow();
    drive_load(4'd1, 6'd0, 6'd0);
    drive_start();
    drive_tick();
    n_checks++; if ({hours, minutes, seconds} !== {4'd0, 6'd59, 6'd59}) $display("FAIL borrow_h got %0d:%0d:%0d exp 0:59:59", hours, minutes, seconds); else n_pass++;
    drive_clear();
    drive_load(4'd11, 6'd59, 6'd59);
    n_checks++; if ({hours, minutes, seconds} !== {4'd11, 6'd59, 6'd59}) $display("FAIL max_load got %0d:%0d:%0d exp 11:59:59", hours, minutes, seconds); else n_pass++;
    drive_start();
    drive_tick();
    n_checks++; if ({hours, minutes, seconds} !== {4'd11, 6'd59, 6'd58}) $display("FAIL max_tick got %0d:%0d:%0d exp 11:59:58", hours, minutes, seconds); else n_pass++;
  endtask

  task automatic test_pause();
    drive_clear();
    drive_load(4'd0, 6'd10, 6'd0);
    drive_start();
    tick = 1'b1;
    cyc();
    cyc();
    n_checks++; if ({hours, minutes, seconds} !== {4'd0, 6'd9, 6'd58}) $display("FAIL pause_pre got %0d:%0d:%0d exp 0:9:58", hours, minutes, seconds); else n_pass++;
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    tick = 1'b0;
    n_checks++; if ({hours, minutes, seconds} !== {4'd0, 6'd9, 6'd58}) $display("FAIL pause_tick got %0d:%0d:%0d exp 0:9:58", hours, minutes, seconds); else n_pass++;
    n_checks++; if (dbg_state !== S_PAUSED || running !== 1'b0) $display("FAIL pause_state got %0d/%b exp %0d/0", dbg_state, running, S_PAUSED); else n_pass++;
    drive_tick();
    n_checks++; if ({hours, minutes, seconds} !== {4'd0, 6'd9, 6'd58}) $display("FAIL paused_tick got %0d:%0d:%0d exp 0:9:58", hours, minutes, seconds); else n_pass++;
    drive_start();
    n_checks++; if (running !== 1'b1) $display("FAIL resume got %b exp 1", running); else n_pass++;
    drive_tick();
    n_checks++; if ({hours, minutes, seconds} !== {4'd0, 6'd9, 6'd57}) $display("FAIL resume_tick got %0d:%0d:%0d exp 0:9:57", hours, minutes, seconds); else n_pass++;
  endtask

  task automatic test_load_err();
    drive_pause();
    drive_load(4'd0, 6'd60, 6'd0);
    n_checks++; if (load_err !== 1'b1) $display("FAIL err_m60 got %b exp 1", load_err); else n_pass++;
    n_checks++; if ({hours, minutes, seconds} !== {4'd0, 6'd9, 6'd57} || dbg_state !== S_PAUSED) $display("FAIL err_m60_keep got %0d:%0d:%0d st %0d exp 0:9:57 st %0d", hours, minutes, seconds, dbg_state, S_PAUSED); else n_pass++;
    cyc();
    n_checks++; if (load_err !== 1'b0) $display("FAIL err_pulse_len got %b exp 0", load_err); else n_pass++;
    drive_load(4'd12, 6'd0, 6'd0);
    n_checks++; if (load_err !== 1'b1) $display("FAIL err_h12 got %b exp 1", load_err); else n_pass++;
    n_checks++; if ({hours, minutes, seconds} !== {4'd0, 6'd9, 6'd57} || dbg_state !== S_PAUSED) $display("FAIL err_h12_keep got %0d:%0d:%0d st %0d exp 0:9:57 st %0d", hours, minutes, seconds, dbg_state, S_PAUSED); else n_pass++;
    drive_start();
    drive_load(4'd0, 6'd0, 6'd1);
    n_checks++; if (load_err !== 1'b0 || dbg_state !== S_RUN) $display("FAIL run_load got err=%b st=%0d exp 0/%0d", load_err, dbg_state, S_RUN); else n_pass++;
    n_checks++; if ({hours, minutes, seconds} !== {4'd0, 6'd9, 6'd57}) $display("FAIL run_load_cnt got %0d:%0d:%0d exp 0:9:57", hours, minutes, seconds); else n_pass++;
  endtask

  task automatic test_zero_start();
    drive_clear();
    drive_start();
    n_checks++; if (dbg_state !== S_IDLE || running !== 1'b0) $display("FAIL zero_start got %0d/%b exp %0d/0", dbg_state, running, S_IDLE); else n_pass++;
    drive_load(4'd0, 6'd0, 6'd1);
    drive_start();
    drive_tick();
    n_checks++; if (done !== 1'b1 || expired !== 1'b1) $display("FAIL one_sec got done=%b exp=%b want 1/1", done, expired); else n_pass++;
    drive_load(4'd0, 6'd0, 6'd5);
    n_checks++; if ({hours, minutes, seconds} !== {4'd0, 6'd0, 6'd5} || dbg_state !== S_IDLE) $display("FAIL exp_reload got %0d:%0d:%0d st %0d exp 0:0:5 st %0d", hours, minutes, seconds, dbg_state, S_IDLE); else n_pass++;
    n_checks++; if (expired !== 1'b0) $display("FAIL exp_reload_flag got %b exp 0", expired); else n_pass++;
    drive_start();
    n_checks++; if (running !== 1'b1) $display("FAIL exp_restart got %b exp 1", running); else n_pass++;
  endtask

  task automatic test_async_rst();
    drive_clear();
    drive_load(4'd0, 6'd5, 6'd30);
    drive_start();
    n_checks++; if (running !== 1'b1 || {hours, minutes, seconds} !== {4'd0, 6'd5, 6'd30}) $display("FAIL arst_pre got %b %0d:%0d:%0d exp 1 0:5:30", running, hours, minutes, seconds); else n_pass++;
    async_rst = 1'b1;
    #1;
    n_checks++; if ({hours, minutes, seconds} !== 16'd0) $display("FAIL arst_count got %0d:%0d:%0d exp 0:0:0", hours, minutes, seconds); else n_pass++;
    n_checks++; if ({running, done, expired, load_err} !== 4'b0000 || dbg_state !== S_IDLE) $display("FAIL arst_flags got %b st %0d exp 0000 st %0d", {running, done, expired, load_err}, dbg_state, S_IDLE); else n_pass++;
    cyc();
    async_rst = 1'b0;
    cyc();
    n_checks++; if (done !== 1'b0 || dbg_state !== S_IDLE) $display("FAIL arst_after got done=%b st=%0d exp 0/%0d", done, dbg_state, S_IDLE); else n_pass++;
  endtask

  task automatic test_clear_load();
    drive_load(4'd0, 6'd0, 6'd7);
    clear = 1'b1;
    drive_load(4'd3, 6'd3, 6'd3);
    clear = 1'b0;
    n_checks++; if ({hours, minutes, seconds} !== 16'd0 || dbg_state !== S_IDLE) $display("FAIL clear_load got %0d:%0d:%0d st %0d exp 0:0:0 st %0d", hours, minutes, seconds, dbg_state, S_IDLE); else n_pass++;
    n_checks++; if (load_err !== 1'b0) $display("FAIL clear_load_err got %b exp 0", load_err); else n_pass++;
  endtask

  initial begin
    async_rst = 1'b1;
    tick = 1'b0; clear = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    load_h = 4'd0; load_m = 6'd0; load_s = 6'd0;
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_load_err();
    test_zero_start();
    test_async_rst();
    test_clear_load();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hms_countdown.md
# hms_countdown

Countdown timer in the 12-hour hours/minutes/seconds format of the team's clock blocks. It runs the opposite direction to the free-running clock: it loads a duration, then decrements once per `tick` enable until it reaches 00:00:00. At zero it pulses `done` and holds in an expired state until reloaded or cleared. It sits beside the 12-hour clock, shares its clock and tick source, and drives the same display path.

## Interface
- No parameters. Widths are fixed: hours 4 bits, max 11; minutes and seconds 6 bits, max 59.
- clk  input  1  system clock; all state updates on rising edge
- async_rst  input  1  reset, asynchronous, active-high
- tick  input  1  count enable; one pulse = one second elapsed
- clear  input  1  synchronous clear to IDLE with count 00:00:00
- load  input  1  load request for `load_h`/`load_m`/`load_s`
- load_h  input  4  load value, hours, 0..11
- load_m  input  6  load value, minutes, 0..59
- load_s  input  6  load value, seconds, 0..59
- start  input  1  start or resume counting
- pause  input  1  pause counting
- hours  output  4  current remaining hours
- minutes  output  6  current remaining minutes
- seconds  output  6  current remaining seconds
- running  output  1  high while state is RUN
- done  output  1  one-cycle pulse when the count reaches zero
- expired  output  1  high while state is EXPIRED
- load_err  output  1  one-cycle pulse when a load is rejected

## Operation
- States: IDLE, RUN, PAUSED, EXPIRED. State is encoded internally.
- Reset: state IDLE; `hours`, `minutes` and `seconds` are 0; `running`, `done`, `expired` and `load_err` are 0.
- Per-cycle input priority: `clear` > `load` > `pause` > `start` > `tick`. Only the highest-priority active request acts; all lower requests in that cycle are ignored.
- clear: valid in any state. Next state IDLE, count 0, no `done`.
- load: accepted in IDLE, PAUSED and EXPIRED. Ignored in RUN, with no `load_err`.
  - Valid values (`load_h` ≤ 11, `load_m` ≤ 59, `load_s` ≤ 59): count takes the load values; next state IDLE.
  - Any field out of range: count and state unchanged; `load_err` pulses.
- start:
  - IDLE or PAUSED with nonzero count: next state RUN.
  - Zero count, or any other state: ignored.
- pause: RUN → PAUSED. Ignored in every other state.
- tick in RUN decrements the count by one second:
  - seconds > 0: seconds−1.
  - seconds = 0: seconds becomes 59 and borrows from minutes.
  - Minutes borrow: minutes > 0 gives minutes−1; minutes = 0 gives 59 and borrows from hours.
  - Hours borrow: hours−1. Hours never underflow, because the count is never 0 in RUN.
  - When the count goes from 00:00:01 to 00:00:00: next state EXPIRED and `done` = 1 on the same edge.
- tick in IDLE, PAUSED or EXPIRED: no effect.
- Count range: 00:00:00 to 11:59:59, i.e. 43199 s maximum. Values outside this range are never stored.

## Timing
- All outputs are registered.
- Latency from `load`, `start`, `pause` or `clear` to the visible state/count change: 1 clock.
- Latency from `tick` to the decremented count: 1 clock.
- `done` goes high on the same edge that `seconds`, `minutes` and `hours` all become 0. It is high for exactly 1 cycle.
- `load_err` goes high on the edge after the rejected load. It is high for 1 cycle.
- `running` and `expired` are decoded from the registered state.
- tick and pause in the same cycle while in RUN: pause wins; no decrement.
- Reset mid-RUN: all outputs return to their reset values immediately (asynchronously), with no `done` pulse.
- `tick` held high continuously: one decrement per clock.

## Test plan
- Reset then load 00:00:03, start, three ticks → count 00:00:02, 00:00:01, 00:00:00; `done` high only on the third update edge; `expired` = 1; further ticks leave 00:00:00.
- Load 01:00:00, start, one tick → 00:59:59. Load 11:59:59, start, one tick → 11:59:58.
- Load 00:10:00, start, two ticks → 00:09:58. Pause with tick in the same cycle → PAUSED at 00:09:58. Start → RUN; next tick → 00:09:57.
- Load with `load_m` = 60 → `load_err` 1-cycle pulse; count and state unchanged. Load with `load_h` = 12 → same result. Load during RUN → ignored, no `load_err`.
- Start with count 00:00:00 in IDLE → stays IDLE, `running` = 0. In EXPIRED, load 00:00:05 → IDLE with 00:00:05; start → RUN.
- Assert `async_rst` mid-RUN at 00:05:30 → outputs 0 and state IDLE immediately. Assert `clear` together with `load` → IDLE at 00:00:00; the load is ignored.
